// File: rtl/udp_hdmi_send.sv
`default_nettype none
// ============================================================================
// Module   : udp_hdmi_send
// Brief    : Reads one DRAM burst into a FIFO and sends it as a UDP packet
//            (4 header words, 1 address word, N payload words).
// Revision : 1.0
// ============================================================================
module udp_hdmi_send #(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [7:0]            start_len,
    input  logic [31:0]           dst_ip,
    input  logic [31:0]           port_pair,
    output logic                  busy,
    output logic                  done,
    output logic [39:0]           ctrl_in,
    output logic                  ctrl_we,
    input  logic [31:0]           data_out,
    input  logic [CNT_WIDTH-1:0]  data_count,
    output logic                  data_re,
    output logic                  w_req,
    input  logic                  w_ack,
    output logic                  w_enable,
    output logic [31:0]           w_data
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CMD    = 3'd1,
        S_FILL   = 3'd2,
        S_REQ    = 3'd3,
        S_HEADER = 3'd4,
        S_ADDR   = 3'd5,
        S_DATA   = 3'd6,
        S_DONE   = 3'd7
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [31:0]           dst_ip_q, dst_ip_d;
    logic [31:0]           port_pair_q, port_pair_d;
    logic [1:0]            hdr_cnt_q, hdr_cnt_d;
    logic [7:0]            word_cnt_q, word_cnt_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  ctrl_we_q, ctrl_we_d;
    logic [39:0]           ctrl_in_q, ctrl_in_d;
    logic                  w_req_q, w_req_d;
    logic                  w_enable_q, w_enable_d;
    logic [31:0]           w_data_q, w_data_d;

    logic [31:0]           byte_addr;
    logic [31:0]           hdr_len;

    assign byte_addr = 32'({start_addr, 2'b00});
    // Byte count covers the address word plus the payload.
    assign hdr_len   = 32'({1'b0, len_q} + 9'd1) << 2;

    // Registered outputs are loaded on the edge that leaves each state, so
    // the word for a state appears on w_data during the following cycle.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        dst_ip_d    = dst_ip_q;
        port_pair_d = port_pair_q;
        hdr_cnt_d   = hdr_cnt_q;
        word_cnt_d  = word_cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        ctrl_we_d   = 1'b0;
        ctrl_in_d   = ctrl_in_q;
        w_req_d     = w_req_q;
        w_enable_d  = w_enable_q;
        w_data_d    = w_data_q;
        data_re     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && (start_len != 8'd0)) begin
                    addr_d      = start_addr;
                    len_d       = start_len;
                    dst_ip_d    = dst_ip;
                    port_pair_d = port_pair;
                    busy_d      = 1'b1;
                    ctrl_we_d   = 1'b1;
                    ctrl_in_d   = {start_len, byte_addr};
                    state_d     = S_CMD;
                end
            end
            S_CMD: state_d = S_FILL;
            S_FILL: begin
                if (data_count >= CNT_WIDTH'(len_q)) begin
                    w_req_d = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (w_ack) begin
                    w_req_d    = 1'b0;
                    w_enable_d = 1'b1;
                    w_data_d   = dst_ip_q;
                    hdr_cnt_d  = 2'd1;
                    state_d    = S_HEADER;
                end
            end
            S_HEADER: begin
                case (hdr_cnt_q)
                    2'd1:    w_data_d = port_pair_q;
                    2'd2:    w_data_d = 32'h0;
                    2'd3:    w_data_d = hdr_len;
                    default: w_data_d = dst_ip_q;
                endcase
                hdr_cnt_d = hdr_cnt_q + 2'd1;
                if (hdr_cnt_q == 2'd3) begin
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                w_data_d   = 32'(addr_q);
                word_cnt_d = 8'd0;
                state_d    = S_DATA;
            end
            S_DATA: begin
                data_re  = 1'b1;
                w_data_d = data_out;
                if (word_cnt_q == len_q - 8'd1) begin
                    state_d = S_DONE;
                end else begin
                    word_cnt_d = word_cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                w_enable_d = 1'b0;
                done_d     = 1'b1;
                busy_d     = 1'b0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            len_q       <= 8'd0;
            dst_ip_q    <= 32'h0;
            port_pair_q <= 32'h0;
            hdr_cnt_q   <= 2'd0;
            word_cnt_q  <= 8'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ctrl_we_q   <= 1'b0;
            ctrl_in_q   <= 40'h0;
            w_req_q     <= 1'b0;
            w_enable_q  <= 1'b0;
            w_data_q    <= 32'h0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            dst_ip_q    <= dst_ip_d;
            port_pair_q <= port_pair_d;
            hdr_cnt_q   <= hdr_cnt_d;
            word_cnt_q  <= word_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ctrl_we_q   <= ctrl_we_d;
            ctrl_in_q   <= ctrl_in_d;
            w_req_q     <= w_req_d;
            w_enable_q  <= w_enable_d;
            w_data_q    <= w_data_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign ctrl_we  = ctrl_we_q;
    assign ctrl_in  = ctrl_in_q;
    assign w_req    = w_req_q;
    assign w_enable = w_enable_q;
    assign w_data   = w_data_q;

endmodule
`default_nettype wire

// File: doc/udp_hdmi_send.md
Name: udp_hdmi_send

Overview:
- Transmit counterpart of the UDP frame receiver.
- On a start pulse it issues one DRAM read burst, waits until the read-data FIFO holds the whole burst, then sends one UDP packet on the w_* interface: 4 header words, 1 address word, N payload words.
- The packet layout matches what the receiver consumes, so a frame line read here can be written back verbatim at the far end.

Parameters:
- ADDR_WIDTH, 32, width of the DRAM word address and of the address word sent in the packet.
- CNT_WIDTH, 9, width of the read-data FIFO occupancy input (holds 0..256).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request pulse; sampled only in s_idle.
- start_addr  in  32  DRAM word address of the burst (byte address = start_addr<<2).
- start_len  in  8  payload length N in 32-bit words, valid range 1..255.
- dst_ip  in  32  destination IP, sent as header word 0.
- port_pair  in  32  {src_port[31:16], dst_port[15:0]}, sent as header word 1.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the last packet word.
- ctrl_in  out  40  DRAM read command {len[39:32], byte_addr[31:0]}.
- ctrl_we  out  1  one-cycle strobe for ctrl_in.
- data_out  in  32  read-data FIFO head word (first-word-fall-through).
- data_count  in  CNT_WIDTH  read-data FIFO occupancy in words.
- data_re  out  1  FIFO pop.
- w_req  out  1  transmit request to the UDP stack.
- w_ack  in  1  grant from the UDP stack.
- w_enable  out  1  packet word valid.
- w_data  out  32  packet word.

Behaviour:
- Reset (async, rst_n=0): state=s_idle; busy, done, ctrl_we, data_re, w_req, w_enable = 0; w_data = 0; ctrl_in = 0. Reset mid-packet aborts immediately. FIFO residue is not flushed here; the FIFO owner clears it.
- s_idle: on start=1 with start_len!=0, latch addr, len, dst_ip and port_pair, set busy=1, go to s_cmd. start with start_len=0, or any start outside s_idle, is ignored (no done).
- s_cmd (1 cycle): ctrl_we=1, ctrl_in={len, addr<<2}; go to s_fill. The DRAM command path has no backpressure; its FIFO depth covers one outstanding command.
- s_fill: wait while data_count < len, with no timeout. When data_count >= len, go to s_req.
- s_req: w_req=1 and held until w_ack is sampled 1, then go to s_header. w_req drops in the same edge that raises w_enable.
- s_header: 4 cycles, counted by a 2-bit hdr_cnt.
  - H0 = dst_ip
  - H1 = port_pair
  - H2 = 32'h0
  - H3 = byte length = (len+1)*4, covering the address word plus payload.
- s_addr (1 cycle): w_data = latched word address (not shifted).
- s_data: N cycles; data_re=1 each cycle and w_data <= data_out. An 8-bit word counter runs 0..len-1 and exits at len-1.
- s_done (1 cycle): done=1, busy=0, w_enable=0, then back to s_idle.
- w_enable and w_data are registered. w_enable stays high for exactly 5+N consecutive cycles with no gaps; w_data is meaningful only while w_enable=1 and is held otherwise.
- data_re is asserted exactly N times per packet.
- Arithmetic: the length multiply is 9-bit zero-extended to 32; the max is (255+1)*4 = 1024.
- Consistency with the receiver: ceil(H3/4)-2 = N-1, i.e. the receiver's end count.

Test Plan:
- Basic: start, start_addr=0x100, len=4, data_count=4 preloaded, w_ack tied 1 -> ctrl_in=0x04_00000400 with one ctrl_we pulse; 9 words dst_ip, port_pair, 0, 20, 0x100, D0..D3 on consecutive cycles; done 1 cycle after the last word; 4 data_re pulses.
- FIFO fill stall: len=8, data_count ramps 0..8 over 50 cycles -> w_req stays 0 until count>=8, then the packet is sent intact.
- Ack delay: w_ack held 0 for 20 cycles -> w_req held for 20 cycles, w_enable=0 throughout, and the header starts the cycle after w_ack=1.
- Boundaries: len=1 -> H3=8 and 6 words; len=255 -> H3=1024 and 260 words with no gaps; len=0 -> no ctrl_we, busy stays 0.
- start while busy: a second start mid-packet -> ignored, exactly one ctrl_we and one done.
- Reset mid-payload: rst_n=0 during s_data -> all outputs 0 asynchronously; after release, a new start produces a clean packet.
